// File: rtl/centroid_divider_seq.sv
// Sequential k-means centroid divider: one shared restoring divider produces one
// quotient bit per cycle for each coordinate, then the packed result is published on done.
module centroid_divider_seq #(
  parameter int DIMS             = 7,
  parameter int ACCUM_CORD_WIDTH = 22,
  parameter int COUNT_WIDTH      = 10,
  parameter int FRAC_BITS        = 0,
  parameter int TC_MODE          = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [DIMS*ACCUM_CORD_WIDTH-1:0]   accumulator,
  input  logic [COUNT_WIDTH-1:0]             counter,
  input  logic [DIMS*ACCUM_CORD_WIDTH-1:0]   old_centroid,
  output logic                               busy,
  output logic                               done,
  output logic [DIMS*ACCUM_CORD_WIDTH-1:0]   new_centroid,
  output logic                               empty_cluster,
  output logic                               overflow
);

  localparam int W     = ACCUM_CORD_WIDTH;
  localparam int CW    = COUNT_WIDTH;
  localparam int QW    = W + FRAC_BITS;
  localparam int IDX_W = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int BIT_W = $clog2(QW + 1);

  localparam logic [QW:0] MAX_POS = {{(QW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic [QW:0] MAG_MIN = MAX_POS + {{QW{1'b0}}, 1'b1};
  localparam logic [QW:0] MAX_U   = {{(QW-W+1){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                state, next_state;
  logic [DIMS*W-1:0]     acc_q, staging, staging_nxt;
  logic [CW-1:0]         cnt_q, rem, rem_nxt;
  logic [QW-1:0]         dvd, quo, quo_full, wb_quo;
  logic [IDX_W-1:0]      idx, nxt_idx, wb_idx;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  neg_q, wb_neg, wb_pend, div_end, ovf_acc, ovf_nxt;
  logic [CW:0]           shifted, div_ext, diff;
  logic                  qbit;
  logic [W:0]            first_split, next_split;
  logic [W-1:0]          sat_val;
  logic                  sat_flag;

  // Returns {negative, magnitude}; the magnitude is formed one bit wider so the
  // most-negative coordinate does not wrap.
  function automatic logic [W:0] split_coord(input logic [W-1:0] c);
    logic       neg;
    logic [W:0] mag_x;
    neg   = (TC_MODE != 0) && c[W-1];
    mag_x = neg ? -{c[W-1], c} : {1'b0, c};
    return {neg, mag_x[W-1:0]};
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = (counter == '0) ? DONE : DIV;
      DIV:  if (div_end) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    shifted  = {rem, dvd[QW-1]};
    div_ext  = {1'b0, cnt_q};
    diff     = shifted - div_ext;
    qbit     = (shifted >= div_ext);
    rem_nxt  = qbit ? diff[CW-1:0] : shifted[CW-1:0];
    quo_full = {quo[QW-2:0], qbit};
    nxt_idx  = (idx == IDX_W'(DIMS-1)) ? '0 : idx + 1'b1;
    first_split = split_coord(accumulator[W-1:0]);
    next_split  = split_coord(acc_q[int'(nxt_idx)*W +: W]);
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sat_val  = wb_quo[W-1:0];
    sat_flag = 1'b0;
    if (TC_MODE != 0) begin
      if (wb_neg) begin
        if ({1'b0, wb_quo} > MAG_MIN) begin
          sat_val  = {1'b1, {(W-1){1'b0}}};
          sat_flag = 1'b1;
        end else begin
          sat_val = -wb_quo[W-1:0];
        end
      end else if ({1'b0, wb_quo} > MAX_POS) begin
        sat_val  = {1'b0, {(W-1){1'b1}}};
        sat_flag = 1'b1;
      end
    end else if ({1'b0, wb_quo} > MAX_U) begin
      sat_val  = {W{1'b1}};
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    staging_nxt = staging;
    if (wb_pend) staging_nxt[int'(wb_idx)*W +: W] = sat_val;
    ovf_nxt = ovf_acc | (wb_pend & sat_flag);
  end

  // A finished quotient is written back one cycle later, so the last coordinate
  // adds a single tail cycle before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0; cnt_q <= '0; staging <= '0;
      rem <= '0; dvd <= '0; quo <= '0; idx <= '0; bit_cnt <= '0; neg_q <= 1'b0;
      wb_quo <= '0; wb_idx <= '0; wb_neg <= 1'b0; wb_pend <= 1'b0;
      div_end <= 1'b0; ovf_acc <= 1'b0;
      new_centroid <= '0; empty_cluster <= 1'b0; overflow <= 1'b0;
    end else begin
      wb_pend <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          acc_q   <= accumulator;
          cnt_q   <= counter;
          ovf_acc <= 1'b0;
          div_end <= 1'b0;
          idx     <= '0;
          bit_cnt <= '0;
          rem     <= '0;
          quo     <= '0;
          dvd     <= QW'(first_split[W-1:0]) << FRAC_BITS;
          neg_q   <= first_split[W];
          if (counter == '0) begin
            new_centroid  <= old_centroid;
            empty_cluster <= 1'b1;
            overflow      <= 1'b0;
          end
        end
        DIV: begin
          if (wb_pend) begin
            staging <= staging_nxt;
            ovf_acc <= ovf_nxt;
          end
          if (!div_end) begin
            rem <= rem_nxt;
            dvd <= dvd << 1;
            quo <= quo_full;
            if (bit_cnt == BIT_W'(QW-1)) begin
              wb_pend <= 1'b1;
              wb_quo  <= quo_full;
              wb_neg  <= neg_q;
              wb_idx  <= idx;
              bit_cnt <= '0;
              if (idx == IDX_W'(DIMS-1)) begin
                div_end <= 1'b1;
              end else begin
                idx   <= nxt_idx;
                rem   <= '0;
                quo   <= '0;
                dvd   <= QW'(next_split[W-1:0]) << FRAC_BITS;
                neg_q <= next_split[W];
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            new_centroid  <= staging_nxt;
            empty_cluster <= 1'b0;
            overflow      <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_divider_seq.sv
// Directed-vector bench for centroid_divider_seq: a default instance and a FRAC_BITS=8
// instance, a vector table plus hand-written reset and handshake sequences.
module tb_centroid_divider_seq;

  localparam int DIMS = 7;
  localparam int W    = 22;
  localparam int CW   = 10;
  localparam int PW   = DIMS * W;

  typedef struct {
    bit            use_f;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [PW-1:0] old;
    logic [PW-1:0] exp_cent;
    logic          exp_empty;
    logic          exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_d = 1'b0, start_f = 1'b0;
  logic [PW-1:0] acc_d = '0, acc_f = '0, old_d = '0, old_f = '0;
  logic [CW-1:0] cnt_d = '0, cnt_f = '0;
  logic          busy_d, done_d, empty_d, ovf_d;
  logic          busy_f, done_f, empty_f, ovf_f;
  logic [PW-1:0] cent_d, cent_f;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[13];

  centroid_divider_seq dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .accumulator(acc_d), .counter(cnt_d),
    .old_centroid(old_d), .busy(busy_d), .done(done_d), .new_centroid(cent_d),
    .empty_cluster(empty_d), .overflow(ovf_d)
  );

  centroid_divider_seq #(.FRAC_BITS(8)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start_f), .accumulator(acc_f), .counter(cnt_f),
    .old_centroid(old_f), .busy(busy_f), .done(done_f), .new_centroid(cent_f),
    .empty_cluster(empty_f), .overflow(ovf_f)
  );

  function automatic logic [PW-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6);
    return {W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic vec_t mk(input bit f, input logic [PW-1:0] acc, input int cnt,
                              input logic [PW-1:0] old, input logic [PW-1:0] ec,
                              input logic ee, input logic eo);
    vec_t v;
    v.use_f = f; v.acc = acc; v.cnt = CW'(cnt); v.old = old;
    v.exp_cent = ec; v.exp_empty = ee; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Start one operation, measure the edges from capture to done, then check outputs.
  task automatic apply(input vec_t v, input string name);
    int cyc;
    int exp_lat;
    @(negedge clk);
    if (v.use_f) begin start_f = 1'b1; acc_f = v.acc; cnt_f = v.cnt; old_f = v.old; end
    else         begin start_d = 1'b1; acc_d = v.acc; cnt_d = v.cnt; old_d = v.old; end
    @(posedge clk);
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (v.use_f) begin start_f = 1'b0; acc_f = ~v.acc; cnt_f = ~v.cnt; old_f = ~v.old; end
        else         begin start_d = 1'b0; acc_d = ~v.acc; cnt_d = ~v.cnt; old_d = ~v.old; end
        check({name, " busy"}, 256'(v.use_f ? busy_f : busy_d), 256'(1));
      end
      if (v.use_f ? done_f : done_d) break;
      cyc++;
    end
    exp_lat = (v.cnt == '0) ? 0 : DIMS * (W + (v.use_f ? 8 : 0)) + 1;
    check({name, " latency"}, 256'(cyc), 256'(exp_lat));
    check({name, " centroid"}, 256'(v.use_f ? cent_f : cent_d), 256'(v.exp_cent));
    check({name, " empty"}, 256'(v.use_f ? empty_f : empty_d), 256'(v.exp_empty));
    check({name, " overflow"}, 256'(v.use_f ? ovf_f : ovf_d), 256'(v.exp_ovf));
    @(negedge clk);
    check({name, " done pulse"}, 256'(v.use_f ? {done_f, busy_f} : {done_d, busy_d}), 256'(0));
  endtask

  initial begin
    int ndone;
    int done_k;

    vecs[0]  = mk(0, pk(3584, 0, 0, 0, 0, 0, 0), 2, pk(9, 9, 9, 9, 9, 9, 9),
                  pk(1792, 0, 0, 0, 0, 0, 0), 0, 0);
    vecs[1]  = mk(0, pk(-1528, 0, -907, 0, 0, 0, 0), 11, '0,
                  pk(-138, 0, -82, 0, 0, 0, 0), 0, 0);
    vecs[2]  = mk(0, pk(100, 1, 2, 3, 4, 5, 6), 0, pk(5, 5, 5, 5, 5, 5, 5),
                  pk(5, 5, 5, 5, 5, 5, 5), 1, 0);
    vecs[3]  = mk(0, pk(-2097152, 2097151, -1, 1, 0, 12345, -54321), 1, '0,
                  pk(-2097152, 2097151, -1, 1, 0, 12345, -54321), 0, 0);
    vecs[4]  = mk(0, pk(2097151, -2097152, 1022, -1022, 1023, -1023, 0), 1023, '0,
                  pk(2050, -2050, 0, 0, 1, -1, 0), 0, 0);
    vecs[5]  = mk(0, pk(100, -100, 6, -6, 7, -7, 700), 7, '0,
                  pk(14, -14, 0, 0, 1, -1, 100), 0, 0);
    vecs[6]  = mk(0, pk(11, 22, 33, 44, 55, 66, 77), 0, pk(-1, 2, -3, 4, -5, 6, -7),
                  pk(-1, 2, -3, 4, -5, 6, -7), 1, 0);
    vecs[7]  = mk(0, pk(10, 20, 30, -10, -20, -30, 1), 3, '0,
                  pk(3, 6, 10, -3, -6, -10, 0), 0, 0);
    vecs[8]  = mk(1, pk(1693, 0, 0, 0, 0, 0, 0), 13, '0, pk(33339, 0, 0, 0, 0, 0, 0), 0, 0);
    vecs[9]  = mk(1, pk(1048576, 0, 0, 0, 0, 0, 0), 1, '0, pk(2097151, 0, 0, 0, 0, 0, 0), 0, 1);
    vecs[10] = mk(1, pk(-5, 0, 0, 0, 0, 0, 0), 2, '0, pk(-640, 0, 0, 0, 0, 0, 0), 0, 0);
    vecs[11] = mk(1, pk(-1048577, 3, 0, 0, 0, 0, 0), 1, '0,
                  pk(-2097152, 768, 0, 0, 0, 0, 0), 0, 1);
    vecs[12] = mk(1, pk(8191, -8192, 0, 0, 0, 0, 0), 1, '0,
                  pk(2096896, -2097152, 0, 0, 0, 0, 0), 0, 0);

    // Reset state.
    #12;
    check("reset outputs", 256'({busy_d, done_d, empty_d, ovf_d, cent_d}), 256'(0));
    check("reset outputs f", 256'({busy_f, done_f, empty_f, ovf_f, cent_f}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a division.
    apply(vecs[2], "pre-reset");
    @(negedge clk);
    acc_d = vecs[1].acc; cnt_d = vecs[1].cnt; start_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_d = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    check("busy before reset", 256'(busy_d), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mid-div reset", 256'({busy_d, done_d, empty_d, ovf_d, cent_d}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(vecs[1], "after reset");

    // Handshake: start while busy and start during DONE are both ignored.
    apply(vecs[5], "pre-handshake");
    @(negedge clk);
    acc_d = vecs[7].acc; cnt_d = vecs[7].cnt; old_d = '0; start_d = 1'b1;
    @(posedge clk);
    ndone = 0;
    done_k = -10;
    for (int k = 0; k < 175; k++) begin
      @(negedge clk);
      if (k == 0)  start_d = 1'b0;
      if (k == 20) begin start_d = 1'b1; cnt_d = '0; old_d = pk(1, 1, 1, 1, 1, 1, 1); end
      if (k == 21) start_d = 1'b0;
      if (k == 40) check("hold during div", 256'(cent_d), 256'(vecs[5].exp_cent));
      if (k == done_k + 1) start_d = 1'b0;
      if (done_d) begin
        ndone++;
        done_k = k;
        start_d = 1'b1;
        cnt_d = '0;
        old_d = pk(2, 2, 2, 2, 2, 2, 2);
      end
    end
    start_d = 1'b0;
    check("handshake done count", 256'(ndone), 256'(1));
    check("handshake latency", 256'(done_k), 256'(DIMS * W + 1));
    check("handshake centroid", 256'(cent_d), 256'(vecs[7].exp_cent));
    check("handshake flags", 256'({busy_d, empty_d, ovf_d}), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/centroid_divider_seq.md
Name: centroid_divider_seq

Overview:
Sequential, parametrised successor to the combinational per-cluster coordinate divider in the k-means centroid-update path. For one cluster it takes the packed per-coordinate accumulator sums and the member count, and divides each signed coordinate by the count. It uses a single shared radix-2 restoring divider and produces an optional fixed-point fraction. The result is a packed new centroid; the old centroid is kept when the cluster is empty. It sits between the accumulation stage and the centroid memory write-back, and connects through a start/done handshake.

Parameters:
DIMS, 7, number of coordinates per point
ACCUM_CORD_WIDTH, 22, width of each accumulated coordinate and of each result coordinate (two's complement when TC_MODE=1)
COUNT_WIDTH, 10, width of the cluster member count
FRAC_BITS, 0, fractional bits in the result; the dividend is left-shifted by FRAC_BITS before division
TC_MODE, 1, 1 = signed coordinates, 0 = unsigned

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
accumulator  input  DIMS*ACCUM_CORD_WIDTH  packed sums; coordinate 0 in the LSBs
counter  input  COUNT_WIDTH  cluster member count (unsigned)
old_centroid  input  DIMS*ACCUM_CORD_WIDTH  current centroid, used when counter==0
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; new_centroid valid
new_centroid  output  DIMS*ACCUM_CORD_WIDTH  packed result; coordinate 0 in the LSBs
empty_cluster  output  1  the last operation had counter==0
overflow  output  1  at least one coordinate saturated in the last operation

Behaviour:
- Reset (async, rst_n=0): state goes to IDLE. busy, done, empty_cluster, overflow and new_centroid all go to 0, also in the middle of an operation. The partial result is discarded.
- States: IDLE, DIV, DONE.
- IDLE:
  - start=1 at an edge captures accumulator, counter and old_centroid into internal registers.
  - If counter!=0, the next state is DIV and the coordinate index is 0.
  - If counter==0, the next state is DONE, with new_centroid<=old_centroid, empty_cluster<=1 and overflow<=0.
- Inputs may change freely after the capture edge.
- DIV: QW = ACCUM_CORD_WIDTH+FRAC_BITS cycles per coordinate, one quotient bit per cycle, MSB first.
  - Dividend is |coord|<<FRAC_BITS; the magnitude is taken only when TC_MODE=1.
  - Divisor is counter zero-extended.
  - Quotient is truncated toward zero, and negated if the coordinate was negative.
  - If the signed quotient exceeds the ACCUM_CORD_WIDTH range, it saturates to the max/min value (unsigned max when TC_MODE=0) and overflow is set.
  - The result is written into its slice of the new_centroid staging register.
  - After coordinate DIMS-1 completes, the next state is DONE.
- DONE: lasts one cycle.
  - done=1, and new_centroid, empty_cluster and overflow are updated at entry to DONE.
  - Next state is IDLE.
- Latency:
  - Nonzero count: done is high in the cycle beginning DIMS*QW+1 edges after the start-capture edge (defaults: 155).
  - Zero count: done is high in the cycle after the capture edge.
- busy is high in DIV and DONE, and low in IDLE. start while busy is ignored (not queued). start asserted in the DONE cycle is ignored.
- new_centroid, empty_cluster and overflow hold their values until the next DONE. Intermediate coordinates must not be visible on new_centroid before done; new_centroid is a separate output register from the staging register.
- Edge cases:
  - counter==1: result equals the input, unless FRAC_BITS causes saturation.
  - Most-negative coordinate with TC_MODE=1: the magnitude is computed at ACCUM_CORD_WIDTH+1 bits so there is no wrap.
  - Coordinate value 0: result is 0 with positive sign.

Test Plan:
1. Reset mid-DIV: assert rst_n=0 while busy -> busy=0, done=0 and new_centroid=0 immediately (asynchronously); the next start runs a full latency.
2. Defaults, start with coord0=3584, other coords 0, counter=2 -> done after 155 cycles; coord0=1792, others 0; overflow=0, empty_cluster=0.
3. Defaults, coord0=22'b1111111111101000001000 (-1528), coord2=22'b1111111111110001110101 (-907), counter=11 -> coord0=-138, coord2=-82, coord1=0; truncation is toward zero.
4. Zero count: counter=0, old_centroid=all coords 5 -> done 1 cycle after start, new_centroid=old_centroid, empty_cluster=1.
5. FRAC_BITS=8 instance: coord0=1693, counter=13 -> coord0=33339 (130.23 in Q.8). With coord0=2^20 and counter=1 -> coord0=2097151, overflow=1.
6. Handshake: pulse start again while busy, and in the DONE cycle -> both ignored; exactly one done pulse; outputs unchanged until a new start accepted in IDLE.
